// File: rtl/nibble_serial_add_ctrl.sv
// Serial add/subtract sequencer driving an external 4-bit adder slice, one nibble per cycle.
// Optional NIBBLE_SERIAL_B2B_EN: accept the next operation on the same edge the result is taken.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [3:0]       fa_a,
    output logic [3:0]       fa_b,
    output logic             fa_cin,
    input  logic [3:0]       fa_s,
    input  logic             fa_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             load, last;

    function automatic logic [3:0] nib(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] i);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (IDX_W'(k) == i) r = v[4*k +: 4];
        end
        return r;
    endfunction

    assign last = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fa_a      = 4'h0;
        fa_b      = 4'h0;
        fa_cin    = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
            end
            S_RUN: begin
                fa_a    = nib(a_q, idx_q);
                fa_b    = nib(b_q, idx_q);
                fa_cin  = carry_q;
                carry_d = fa_cout;
                for (int k = 0; k < NIBBLES; k++) begin
                    if (IDX_W'(k) == idx_q) sum_d[4*k +: 4] = fa_s;
                end
                if (last) begin
                    idx_d   = '0;
                    cout_d  = fa_cout;
                    // Signed overflow: like-signed operands whose top result bit flips sign.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_s[3] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
`ifdef NIBBLE_SERIAL_B2B_EN
                in_ready  = out_ready;
                load      = out_ready && in_valid;
`endif
                if (out_ready && !load) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            a_d     = op_a;
            b_d     = op_sub ? ~op_b : op_b;
            carry_d = op_sub ? 1'b1 : op_cin;
            idx_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule
